// File: rtl/lenet_layer_sequencer.sv
// Sequences the shared compute engine through the seven LeNet layer passes, then argmaxes the logits.
// Optional per-pass watchdog enabled by defining LENET_SEQ_WATCHDOG_EN.
module lenet_layer_sequencer #(
    parameter int unsigned N           = 16,
    parameter int unsigned WDOG_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                eng_start_o,
    output logic [2:0]          eng_layer_o,
    output logic [10:0]         eng_in_len_o,
    output logic [10:0]         eng_out_len_o,
    input  logic                eng_done_i,
    output logic                logit_rd_en_o,
    output logic [3:0]          logit_rd_idx_o,
    input  logic signed [N-1:0] logit_rd_data_i,
    output logic [3:0]          predicted_class,
    output logic                output_valid,
    output logic                error_o
);

    typedef enum logic [2:0] {
        StIdle,
        StCfg,
        StLaunch,
        StWait,
        StRd,
        StCmp,
        StDone
    } state_e;

    state_e              state_q;
    logic signed [N-1:0] max_q;
    logic [3:0]          cls_q;
    logic [2:0]          next_layer;

    assign next_layer = eng_layer_o + 3'd1;

    function automatic logic [10:0] layer_in_len(input logic [2:0] layer);
        case (layer)
            3'd0:    return 11'd1024;
            3'd1:    return 11'd784;
            3'd2:    return 11'd196;
            3'd3:    return 11'd100;
            3'd4:    return 11'd400;
            3'd5:    return 11'd120;
            3'd6:    return 11'd84;
            default: return 11'd0;
        endcase
    endfunction

    function automatic logic [10:0] layer_out_len(input logic [2:0] layer);
        case (layer)
            3'd0:    return 11'd784;
            3'd1:    return 11'd196;
            3'd2:    return 11'd100;
            3'd3:    return 11'd25;
            3'd4:    return 11'd120;
            3'd5:    return 11'd84;
            3'd6:    return 11'd10;
            default: return 11'd0;
        endcase
    endfunction

`ifdef LENET_SEQ_WATCHDOG_EN
    localparam int unsigned          WdogW     = $clog2(WDOG_CYCLES + 1);
    localparam logic [WdogW-1:0]     WdogLimit = WdogW'(WDOG_CYCLES - 1);
    logic [WdogW-1:0]                wdog_cnt_q;
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
    assign error_o     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            busy_o          <= 1'b0;
            eng_start_o     <= 1'b0;
            eng_layer_o     <= 3'd0;
            eng_in_len_o    <= 11'd0;
            eng_out_len_o   <= 11'd0;
            logit_rd_en_o   <= 1'b0;
            logit_rd_idx_o  <= 4'd0;
            predicted_class <= 4'd0;
            output_valid    <= 1'b0;
            max_q           <= '0;
            cls_q           <= 4'd0;
`ifdef LENET_SEQ_WATCHDOG_EN
            wdog_cnt_q      <= '0;
            error_o         <= 1'b0;
`endif
        end else begin
            eng_start_o  <= 1'b0;
            output_valid <= 1'b0;
            if (abort_i && state_q != StIdle) begin
                state_q        <= StIdle;
                busy_o         <= 1'b0;
                logit_rd_en_o  <= 1'b0;
                logit_rd_idx_o <= 4'd0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            state_q       <= StCfg;
                            busy_o        <= 1'b1;
                            eng_layer_o   <= 3'd0;
                            eng_in_len_o  <= layer_in_len(3'd0);
                            eng_out_len_o <= layer_out_len(3'd0);
`ifdef LENET_SEQ_WATCHDOG_EN
                            error_o       <= 1'b0;
`endif
                        end
                    end
                    StCfg: begin
                        state_q     <= StLaunch;
                        eng_start_o <= 1'b1;
                    end
                    StLaunch: begin
                        state_q <= StWait;
`ifdef LENET_SEQ_WATCHDOG_EN
                        wdog_cnt_q <= '0;
`endif
                    end
                    StWait: begin
                        if (eng_done_i) begin
                            if (eng_layer_o == 3'd6) begin
                                state_q        <= StRd;
                                logit_rd_en_o  <= 1'b1;
                                logit_rd_idx_o <= 4'd0;
                            end else begin
                                state_q       <= StCfg;
                                eng_layer_o   <= next_layer;
                                eng_in_len_o  <= layer_in_len(next_layer);
                                eng_out_len_o <= layer_out_len(next_layer);
                            end
                        end
`ifdef LENET_SEQ_WATCHDOG_EN
                        // A done arriving on the limit cycle wins over the timeout.
                        else if (wdog_cnt_q == WdogLimit) begin
                            state_q <= StIdle;
                            busy_o  <= 1'b0;
                            error_o <= 1'b1;
                        end else begin
                            wdog_cnt_q <= wdog_cnt_q + WdogW'(1);
                        end
`endif
                    end
                    StRd: begin
                        // Datum for the previous index arrives this cycle.
                        if (logit_rd_idx_o == 4'd1) begin
                            max_q <= logit_rd_data_i;
                            cls_q <= 4'd0;
                        end else if (logit_rd_idx_o > 4'd1 && logit_rd_data_i > max_q) begin
                            max_q <= logit_rd_data_i;
                            cls_q <= logit_rd_idx_o - 4'd1;
                        end
                        if (logit_rd_idx_o == 4'd9) begin
                            state_q        <= StCmp;
                            logit_rd_en_o  <= 1'b0;
                            logit_rd_idx_o <= 4'd0;
                        end else begin
                            logit_rd_idx_o <= logit_rd_idx_o + 4'd1;
                        end
                    end
                    StCmp: begin
                        if (logit_rd_data_i > max_q) begin
                            max_q <= logit_rd_data_i;
                            cls_q <= 4'd9;
                        end
                        state_q <= StDone;
                    end
                    StDone: begin
                        predicted_class <= cls_q;
                        output_valid    <= 1'b1;
                        busy_o          <= 1'b0;
                        state_q         <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lenet_layer_sequencer.sv
// Bench for lenet_layer_sequencer: engine and logit-memory models, table vectors, random logits.
module tb_lenet_layer_sequencer;

    localparam int N = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                start_i;
    logic                abort_i;
    logic                busy_o;
    logic                eng_start_o;
    logic [2:0]          eng_layer_o;
    logic [10:0]         eng_in_len_o;
    logic [10:0]         eng_out_len_o;
    logic                eng_done_i;
    logic                logit_rd_en_o;
    logic [3:0]          logit_rd_idx_o;
    logic signed [N-1:0] logit_rd_data_i;
    logic [3:0]          predicted_class;
    logic                output_valid;
    logic                error_o;

    lenet_layer_sequencer #(
        .N           (N),
        .WDOG_CYCLES (20)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .busy_o          (busy_o),
        .eng_start_o     (eng_start_o),
        .eng_layer_o     (eng_layer_o),
        .eng_in_len_o    (eng_in_len_o),
        .eng_out_len_o   (eng_out_len_o),
        .eng_done_i      (eng_done_i),
        .logit_rd_en_o   (logit_rd_en_o),
        .logit_rd_idx_o  (logit_rd_idx_o),
        .logit_rd_data_i (logit_rd_data_i),
        .predicted_class (predicted_class),
        .output_valid    (output_valid),
        .error_o         (error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [159:0] lg;
        int           lat;
        int           cls;
        int           mode;  // 0 plain, 1 start-while-busy + spurious done, 2 start with abort
    } vec_t;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int passes, valids, eng_cnt, eng_lat, last_exp;
    int hold_layer = -1;
    bit last_done, rd_pend;
    logic [3:0] rd_pend_idx;
    logic signed [15:0] logits [10];
    int tab_in  [7] = '{1024, 784, 196, 100, 400, 120, 84};
    int tab_out [7] = '{784, 196, 100, 25, 120, 84, 10};
    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge, models drive inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
        last_done = eng_done_i;
        if (rd_pend) logit_rd_data_i = logits[rd_pend_idx];
        else logit_rd_data_i = 16'($urandom);
        rd_pend     = logit_rd_en_o;
        rd_pend_idx = logit_rd_idx_o;
        eng_done_i = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) eng_done_i = 1'b1;
        end
        if (eng_start_o) begin
            if (passes < 7) begin
                check("pass_layer", int'(eng_layer_o), passes);
                check("pass_in_len", int'(eng_in_len_o), tab_in[passes]);
                check("pass_out_len", int'(eng_out_len_o), tab_out[passes]);
            end
            passes++;
            if (int'(eng_layer_o) != hold_layer) eng_cnt = eng_lat;
        end
        if (output_valid) valids++;
    endtask

    function automatic logic [159:0] pack10(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5,
                                            input int a6, input int a7, input int a8,
                                            input int a9);
        int a [10];
        logic [159:0] v;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8, a9};
        v = '0;
        for (int i = 0; i < 10; i++) v[16*i +: 16] = a[i][15:0];
        return v;
    endfunction

    function automatic vec_t mk(input logic [159:0] lg, input int lat, input int cls,
                                input int mode);
        vec_t v;
        v.lg = lg;
        v.lat = lat;
        v.cls = cls;
        v.mode = mode;
        return v;
    endfunction

    task automatic load(input logic [159:0] lg);
        for (int i = 0; i < 10; i++) logits[i] = lg[16*i +: 16];
    endtask

    // Reference: first strictly greatest signed logit.
    function automatic int ref_argmax();
        int best = 0;
        for (int i = 1; i < 10; i++) if (logits[i] > logits[best]) best = i;
        return best;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_eng_start"}, int'(eng_start_o), 0);
        check({tag, "_layer"}, int'(eng_layer_o), 0);
        check({tag, "_in_len"}, int'(eng_in_len_o), 0);
        check({tag, "_out_len"}, int'(eng_out_len_o), 0);
        check({tag, "_rd_en"}, int'(logit_rd_en_o), 0);
        check({tag, "_rd_idx"}, int'(logit_rd_idx_o), 0);
        check({tag, "_class"}, int'(predicted_class), 0);
        check({tag, "_valid"}, int'(output_valid), 0);
        check({tag, "_error"}, int'(error_o), 0);
    endtask

    task automatic run_inf(input string tag, input int mode, input int exp_cls, input int lat);
        int t0;
        bit got, did_start, did_spur;
        eng_lat = lat;
        eng_cnt = 0;
        passes = 0;
        valids = 0;
        start_i = 1'b1;
        abort_i = (mode == 2);
        t0 = cycle;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        check({tag, "_busy_on"}, int'(busy_o), 1);
        check({tag, "_error_clr"}, int'(error_o), 0);
        got = 0;
        did_start = 0;
        did_spur = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            if (output_valid) begin
                got = 1;
            end else begin
                if (mode == 1 && !did_start && eng_start_o && eng_layer_o == 3'd3) begin
                    start_i = 1'b1;
                    did_start = 1;
                end
                // Previous cycle carried layer 3's done, so the DUT is now in CFG.
                if (mode == 1 && !did_spur && last_done && eng_layer_o == 3'd4) begin
                    eng_done_i = 1'b1;
                    did_spur = 1;
                end
                tick();
                start_i = 1'b0;
            end
        end
        check({tag, "_valid_seen"}, int'(got), 1);
        if (got) begin
            check({tag, "_latency"}, cycle - t0, 7 * (2 + lat) + 13);
            check({tag, "_class"}, int'(predicted_class), exp_cls);
            check({tag, "_passes"}, passes, 7);
            check({tag, "_busy_off"}, int'(busy_o), 0);
            tick();
            check({tag, "_valid_pulse"}, int'(output_valid), 0);
            check({tag, "_valid_count"}, valids, 1);
        end
        last_exp = exp_cls;
    endtask

    initial begin
        bit found;
        int style, exp;
        int ext [4] = '{-32768, 32767, -1, 0};

        reset = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        eng_done_i = 1'b0;
        logit_rd_data_i = '0;
        eng_cnt = 0;
        rd_pend = 0;
        rd_pend_idx = '0;
        repeat (3) tick();
        check_zero("reset");
        reset = 1'b0;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        tick();
        check_zero("idle_abort");

        vecs[0] = mk(pack10(3, -2, 7, 7, 0, 1, -8, 2, 6, 5), 5, 2, 0);
        vecs[1] = mk(pack10(-5, -5, -5, -5, -5, -5, -5, -5, -5, -1), 5, 9, 0);
        vecs[2] = mk(pack10(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768,
                            -32768, -32768), 5, 0, 0);
        vecs[3] = mk(pack10(-32768, -1, -1, -1, -1, 32767, -1, -1, -1, -1), 1, 5, 0);
        vecs[4] = mk(pack10(0, 1, 2, 3, 4, 5, 6, 7, 8, 9), 3, 9, 2);
        vecs[5] = mk(pack10(9, 8, 7, 6, 5, 4, 3, 2, 1, 0), 2, 0, 0);
        vecs[6] = mk(pack10(-7, -7, -7, 4, -7, 4, 4, -7, -7, -7), 4, 3, 1);
        vecs[7] = mk(pack10(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767,
                            32767), 1, 0, 0);
        for (int v = 0; v < 8; v++) begin
            load(vecs[v].lg);
            run_inf($sformatf("vec%0d", v), vecs[v].mode, vecs[v].cls, vecs[v].lat);
        end

        // Abort in WAIT of layer 4 coinciding with done.
        load(vecs[0].lg);
        eng_lat = 5;
        eng_cnt = 0;
        passes = 0;
        valids = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (eng_done_i && eng_layer_o == 3'd4) begin
                abort_i = 1'b1;
                found = 1;
            end else begin
                tick();
            end
        end
        check("abort_reached", int'(found), 1);
        tick();
        abort_i = 1'b0;
        check("abort_busy", int'(busy_o), 0);
        check("abort_eng_start", int'(eng_start_o), 0);
        repeat (80) tick();
        check("abort_no_valid", valids, 0);
        check("abort_passes", passes, 5);
        check("abort_class_kept", int'(predicted_class), last_exp);
        check("abort_idle_busy", int'(busy_o), 0);
        run_inf("after_abort", 0, 2, 5);

        // Reset while reading logit 4.
        load(vecs[1].lg);
        eng_lat = 2;
        eng_cnt = 0;
        passes = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (logit_rd_en_o && logit_rd_idx_o == 4'd4) begin
                reset = 1'b1;
                found = 1;
            end else begin
                tick();
            end
        end
        check("rst_rd_reached", int'(found), 1);
        tick();
        reset = 1'b0;
        check_zero("rst_mid_rd");
        run_inf("after_rst", 0, 9, 2);

`ifdef LENET_SEQ_WATCHDOG_EN
        // Withhold done on layer 2; limit is 20 WAIT cycles.
        load(vecs[0].lg);
        eng_lat = 3;
        eng_cnt = 0;
        passes = 0;
        valids = 0;
        hold_layer = 2;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (eng_start_o && eng_layer_o == 3'd2) found = 1;
        end
        check("wdog_launch", int'(found), 1);
        repeat (20) tick();
        check("wdog_err_early", int'(error_o), 0);
        check("wdog_busy_early", int'(busy_o), 1);
        tick();
        check("wdog_err", int'(error_o), 1);
        check("wdog_busy", int'(busy_o), 0);
        repeat (30) tick();
        check("wdog_sticky", int'(error_o), 1);
        check("wdog_no_valid", valids, 0);
        hold_layer = -1;
        run_inf("after_wdog", 0, 2, 3);
`endif

        // Random logits against the argmax reference.
        for (int r = 0; r < 24; r++) begin
            style = int'($urandom_range(0, 2));
            for (int i = 0; i < 10; i++) begin
                if (style == 0) logits[i] = 16'($urandom);
                else if (style == 1) logits[i] = 16'(int'($urandom_range(0, 6)) - 3);
                else logits[i] = 16'(ext[$urandom_range(0, 3)]);
            end
            exp = ref_argmax();
            run_inf($sformatf("rand%0d", r), 0, exp, int'($urandom_range(1, 6)));
        end

        check("final_error", int'(error_o), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lenet_layer_sequencer.md
Name: lenet_layer_sequencer

Overview:
Top-level scheduler for the LeNet forward pass on a single shared systolic-array compute engine. On a start request it walks the engine through the seven layer passes (conv1, pool1, conv2, pool2, fc1, fc2, fc3), one start/done handshake per pass. It then reads the 10 fc3 logits serially, performs a signed argmax and reports the predicted class with a valid pulse. It sits between the host/test harness and the engine wrapper, replacing free-running layer chaining with explicit sequencing.

Parameters:
N, 16, logit data width in bits (signed two's complement)
WDOG_CYCLES, 65535, watchdog limit in cycles per layer pass (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on the rising edge
reset  in  1  synchronous, active-high reset
start_i  in  1  begin an inference; sampled only in IDLE
abort_i  in  1  cancel the current inference; return to IDLE
busy_o  out  1  high from the cycle after an accepted start until the cycle after done or abort
eng_start_o  out  1  one-cycle pulse that launches an engine pass
eng_layer_o  out  3  layer id 0..6 for the current pass
eng_in_len_o  out  11  input element count for the current pass
eng_out_len_o  out  11  output element count for the current pass
eng_done_i  in  1  engine pass complete; counted only in WAIT
logit_rd_en_o  out  1  logit read strobe
logit_rd_idx_o  out  4  logit index 0..9
logit_rd_data_i  in  N  logit data, valid exactly one cycle after logit_rd_en_o
predicted_class  out  4  argmax result; held until the next result
output_valid  out  1  one-cycle pulse when predicted_class updates
error_o  out  1  watchdog flag (optional feature; tied 0 otherwise)

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All outputs are 0: busy_o, eng_start_o, eng_layer_o, both len outputs, logit_rd_en_o, logit_rd_idx_o, predicted_class, output_valid, error_o. Reset overrides all other inputs, including mid-inference.
- Layer table (id: in, out): 0 conv1 1024,784; 1 pool1 784,196; 2 conv2 196,100; 3 pool2 100,25; 4 fc1 400,120; 5 fc2 120,84; 6 fc3 84,10.
- States: IDLE, CFG, LAUNCH, WAIT, RD, CMP, DONE.
- IDLE: if start_i=1 -> CFG with layer=0, busy_o=1.
- CFG: drive eng_layer_o and the lengths from the table. These are stable from CFG through the end of WAIT. Next state LAUNCH.
- LAUNCH: eng_start_o=1 for exactly this cycle. Next state WAIT.
- WAIT: on eng_done_i=1: if layer<6, then layer+1 and go to CFG; if layer=6, go to RD with idx=0. eng_done_i is ignored in any state other than WAIT.
- RD: issue reads for idx 0..9 on 10 consecutive cycles (logit_rd_en_o=1). Each returned datum is compared in the following cycle. The final compare happens in CMP, the cycle after idx 9 is issued.
- Argmax: the first datum initialises max and cls=0. Each later datum replaces max/cls only if it is strictly greater (signed N-bit compare). Ties therefore keep the lowest index.
- DONE: predicted_class<=cls, output_valid=1 for one cycle, busy_o=0 from the next cycle, next state IDLE.
- Latency: start to output_valid = 1 + sum over 7 passes of (2 + engine latency) + 11 + 1 cycles.
- start_i while busy: ignored, no queueing.
- abort_i has priority over every event in the same cycle except reset, including eng_done_i. It sends any non-IDLE state to IDLE next cycle: no output_valid, predicted_class unchanged, busy_o=0, eng_start_o forced 0. abort_i in IDLE has no effect.
- start_i and abort_i together in IDLE: the start is accepted.

Optional Feature:
LENET_SEQ_WATCHDOG_EN
- Defined: a cycle counter clears on entry to WAIT and increments each WAIT cycle. If it reaches WDOG_CYCLES without eng_done_i, then error_o<=1 (sticky), state goes to IDLE, busy_o=0, and there is no output_valid. error_o clears on the next accepted start or on reset. eng_done_i arriving in the same cycle as the limit counts as success.
- Not defined: no counter; WAIT waits indefinitely; error_o is constant 0.

Test Plan:
- Nominal: engine model returns done 5 cycles after each start; logits {3,-2,7,7,0,1,-8,2,6,5} -> 7 eng_start pulses with layers 0..6 and lengths matching the table; predicted_class=2 (tie at 2/3 resolves to the lower index); output_valid is a single pulse at the cycle predicted by the latency formula.
- Negative logits: all equal -5 except idx9=-1 -> predicted_class=9. Then all -32768 -> predicted_class=0.
- Start while busy and spurious done: start_i pulsed during layer 3; eng_done_i pulsed in CFG -> no restart, no extra layer advance, 7 passes total.
- Abort in WAIT of layer 4, with eng_done_i in the same cycle -> IDLE next cycle, no output_valid, predicted_class keeps its prior value. A fresh start then completes normally.
- Reset mid-RD (idx=4) -> all outputs 0 the next cycle. A subsequent start runs the full sequence.
- With LENET_SEQ_WATCHDOG_EN and WDOG_CYCLES=20: withhold done on layer 2 -> error_o=1 after 20 WAIT cycles, busy_o=0. The next start clears error_o.
